// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation decode stage.
// Holds the RISC-V base opcodes recognised by the stage and the 3-bit
// format code carried alongside every decoded immediate.
package imm_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_OPIMM   = 7'h13;
    localparam logic [6:0] OPC_JALR    = 7'h67;
    localparam logic [6:0] OPC_SYSTEM  = 7'h73;
    localparam logic [6:0] OPC_OPIMM32 = 7'h1B;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_LUI     = 7'h37;
    localparam logic [6:0] OPC_AUIPC   = 7'h17;
    localparam logic [6:0] OPC_JAL     = 7'h6F;
    localparam logic [6:0] OPC_OP      = 7'h33;
    localparam logic [6:0] OPC_OP32    = 7'h3B;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } imm_fmt_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational format classifier and immediate extractor.
// Ports:
//   i_instr   - raw 32-bit instruction word
//   o_fmt     - instruction format (R/I/S/B/U/J/ILL)
//   o_illegal - opcode not recognised
//   o_imm     - immediate sign-extended from bit 31 to XLEN (0 for R/ILL)
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output imm_fmt_t        o_fmt,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_imm
);

    // Every format's immediate fits in 32 bits; widening to XLEN is a
    // single sign extension afterwards.
    logic [31:0] w_imm32;

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case statements leaves it unassigned (no latch).
    always_comb begin
        o_fmt   = FMT_ILL;
        w_imm32 = '0;

        case (i_instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: o_fmt = FMT_I;
            OPC_OPIMM32:        o_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
            OPC_STORE:          o_fmt = FMT_S;
            OPC_BRANCH:         o_fmt = FMT_B;
            OPC_LUI, OPC_AUIPC: o_fmt = FMT_U;
            OPC_JAL:            o_fmt = FMT_J;
            OPC_OP:             o_fmt = FMT_R;
            OPC_OP32:           o_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
            default:            o_fmt = FMT_ILL;
        endcase

        case (o_fmt)
            FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_illegal = (o_fmt == FMT_ILL);
    assign o_imm     = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage with a two-entry skid buffer.
// Decodes on the input side, then holds results in an output register (OR)
// that drives the out ports and a skid register (SK) that absorbs the one
// extra beat accepted while the consumer stalls.
// Ports:
//   i_clk, i_reset      - clock, synchronous active-high reset
//   i_flush             - discard all buffered entries
//   i_in_valid/o_in_ready, i_in_instr, i_in_tag   - upstream handshake
//   o_out_valid/i_out_ready, o_out_imm, o_out_fmt,
//   o_out_tag, o_out_illegal                      - downstream handshake
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_in_instr,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_out_imm,
    output imm_fmt_t         o_out_fmt,
    output logic [TAG_W-1:0] o_out_tag,
    output logic             o_out_illegal
);

    imm_fmt_t        w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_instr   (i_in_instr),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal),
        .o_imm     (w_imm)
    );

    logic             r_in_ready;
    logic             r_or_valid, r_sk_valid;
    logic [XLEN-1:0]  r_or_imm,   r_sk_imm;
    imm_fmt_t         r_or_fmt,   r_sk_fmt;
    logic [TAG_W-1:0] r_or_tag,   r_sk_tag;
    logic             r_or_ill,   r_sk_ill;

    logic w_accept, w_consume, w_or_free;
    logic w_or_load_sk, w_or_load_in, w_sk_load_in;
    logic w_or_valid_nxt, w_sk_valid_nxt;

    assign w_accept  = i_in_valid && r_in_ready;
    assign w_consume = r_or_valid && i_out_ready;
    // OR can take a new entry when it is empty or draining this cycle.
    assign w_or_free = !r_or_valid || w_consume;

    // SK always has priority into OR so order is preserved; a fresh input
    // goes straight to OR only when nothing older is waiting in SK.
    assign w_or_load_sk = w_or_free && r_sk_valid;
    assign w_or_load_in = w_or_free && !r_sk_valid && w_accept;
    assign w_sk_load_in = w_accept && !w_or_load_in;

    assign w_or_valid_nxt = w_or_load_sk || w_or_load_in || (r_or_valid && !w_consume);
    assign w_sk_valid_nxt = w_sk_load_in || (r_sk_valid && !w_or_load_sk);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: payload registers are reset too, not only the valid
            // bits, because their values are visible on the out ports.
            r_in_ready <= 1'b1;
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
            r_or_imm   <= '0;
            r_or_fmt   <= FMT_R;
            r_or_tag   <= '0;
            r_or_ill   <= 1'b0;
            r_sk_imm   <= '0;
            r_sk_fmt   <= FMT_R;
            r_sk_tag   <= '0;
            r_sk_ill   <= 1'b0;
        end else if (i_flush) begin
            r_in_ready <= 1'b1;
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
        end else begin
            r_or_valid <= w_or_valid_nxt;
            r_sk_valid <= w_sk_valid_nxt;
            // Registered ready: next cycle can accept only if SK will be free.
            r_in_ready <= !w_sk_valid_nxt;

            if (w_or_load_sk) begin
                r_or_imm <= r_sk_imm;
                r_or_fmt <= r_sk_fmt;
                r_or_tag <= r_sk_tag;
                r_or_ill <= r_sk_ill;
            end else if (w_or_load_in) begin
                r_or_imm <= w_imm;
                r_or_fmt <= w_fmt;
                r_or_tag <= i_in_tag;
                r_or_ill <= w_illegal;
            end

            if (w_sk_load_in) begin
                r_sk_imm <= w_imm;
                r_sk_fmt <= w_fmt;
                r_sk_tag <= i_in_tag;
                r_sk_ill <= w_illegal;
            end
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = r_or_valid;
    assign o_out_imm     = r_or_imm;
    assign o_out_fmt     = r_or_fmt;
    assign o_out_tag     = r_or_tag;
    assign o_out_illegal = r_or_ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage; drives an XLEN=32 and an XLEN=64
// instance from the same stimulus and checks each against a reference model.
module tb_imm_decode_stage;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_tag;

    logic        rdy32, val32, ill32, rdy64, val64, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out32 = 0;
    exp_t q32[$];
    exp_t q64[$];
    logic fire;
    vec_t vecs[10];

    logic [6:0] opcs[14] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0B};

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .i_clk(clk), .i_reset(reset), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(rdy32), .i_in_instr(in_instr), .i_in_tag(in_tag),
        .o_out_valid(val32), .i_out_ready(out_ready), .o_out_imm(imm32),
        .o_out_fmt(fmt32), .o_out_tag(tag32), .o_out_illegal(ill32)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .i_clk(clk), .i_reset(reset), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(rdy64), .i_in_instr(in_instr), .i_in_tag(in_tag),
        .o_out_valid(val64), .i_out_ready(out_ready), .o_out_imm(imm64),
        .o_out_fmt(fmt64), .o_out_tag(tag64), .o_out_illegal(ill64)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: immediate as a plain signed number assembled from the
    // field weights, then truncated to the datapath width.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] tag, input int xlen);
        exp_t        e;
        longint      v;
        logic [2:0]  f;
        v = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: f = 3'd1;
            7'h1B:                      f = (xlen == 64) ? 3'd1 : 3'd7;
            7'h23:                      f = 3'd2;
            7'h63:                      f = 3'd3;
            7'h37, 7'h17:               f = 3'd4;
            7'h6F:                      f = 3'd5;
            7'h33:                      f = 3'd0;
            7'h3B:                      f = (xlen == 64) ? 3'd0 : 3'd7;
            default:                    f = 3'd7;
        endcase
        case (f)
            3'd1: v = longint'(ins[31:20]) - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd2: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7])
                      - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd3: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2 - (ins[31] ? 64'sd4096 : 64'sd0);
            3'd4: v = longint'(ins[30:12]) * 4096 - (ins[31] ? 64'sd2147483648 : 64'sd0);
            3'd5: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2 - (ins[31] ? 64'sd1048576 : 64'sd0);
            default: v = 0;
        endcase
        e.imm = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
        e.fmt = f;
        e.ill = (f == 3'd7);
        e.tag = tag;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        r[6:0] = opcs[$urandom_range(0, 13)];
        return r;
    endfunction

    // Input side of the scoreboard: record every handshake; flush/reset
    // discard everything in flight including a same-cycle handshake.
    always @(negedge clk) begin
        if (reset || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (in_valid && rdy32) q32.push_back(model(in_instr, in_tag, 32));
            if (in_valid && rdy64) q64.push_back(model(in_instr, in_tag, 64));
        end
    end

    // Output side: compare each consumed result, and check outputs held
    // stable across stalled cycles.
    logic        stall32 = 1'b0, stall64 = 1'b0;
    logic [99:0] held32, held64;
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !flush) begin
            if (stall32) check("hold32", {tag32, 32'b0, imm32, fmt32, ill32}, held32);
            if (stall64) check("hold64", {tag64, imm64, fmt64, ill64}, held64);
            if (val32 && out_ready) begin
                n_out32++;
                if (q32.size() == 0) check("orphan32", 1, 0);
                else begin
                    e = q32.pop_front();
                    check("out32", {tag32, 32'b0, imm32, fmt32, ill32}, {e.tag, e.imm, e.fmt, e.ill});
                end
            end
            if (val64 && out_ready) begin
                if (q64.size() == 0) check("orphan64", 1, 0);
                else begin
                    e = q64.pop_front();
                    check("out64", {tag64, imm64, fmt64, ill64}, {e.tag, e.imm, e.fmt, e.ill});
                end
            end
        end
        stall32 = val32 && !out_ready && !reset && !flush;
        stall64 = val64 && !out_ready && !reset && !flush;
        held32  = {tag32, 32'b0, imm32, fmt32, ill32};
        held64  = {tag64, imm64, fmt64, ill64};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        check({name, "32"}, {val32, rdy32, imm32, fmt32, tag32, ill32}, {1'b0, 1'b1, 32'h0, 3'd0, 32'h0, 1'b0});
        check({name, "64"}, {val64, rdy64, imm64, fmt64, tag64, ill64}, {1'b0, 1'b1, 64'h0, 3'd0, 32'h0, 1'b0});
    endtask

    initial begin
        vecs[0] = '{32'hFFC12083, 64'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
        vecs[1] = '{32'h00512423, 64'h00000008, 3'd2, 1'b0, 64'h0000000000000008, 3'd2, 1'b0};
        vecs[2] = '{32'hFE000CE3, 64'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0};
        vecs[3] = '{32'h123450B7, 64'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
        vecs[4] = '{32'h0010006F, 64'h00000800, 3'd5, 1'b0, 64'h0000000000000800, 3'd5, 1'b0};
        vecs[5] = '{32'h00000033, 64'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
        vecs[6] = '{32'h0000007F, 64'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b1};
        vecs[7] = '{32'h800000B7, 64'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
        vecs[8] = '{32'h0000001B, 64'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd1, 1'b0};
        vecs[9] = '{32'h0000003B, 64'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd0, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check_reset_state("reset_state");

        // Back-to-back directed vectors: each result visible one cycle after accept.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_instr = vecs[i].instr; in_tag = 100 + i;
            tick();
            check("vec32", {val32, rdy32, tag32, imm32, fmt32, ill32},
                  {1'b1, 1'b1, in_tag, vecs[i].imm32[31:0], vecs[i].fmt32, vecs[i].ill32});
            check("vec64", {val64, tag64, imm64, fmt64, ill64},
                  {1'b1, in_tag, vecs[i].imm64, vecs[i].fmt64, vecs[i].ill64});
        end
        in_valid = 1'b0;
        tick(); tick();

        // Back-pressure: tags 1..4 with the consumer stalled.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = rand_instr(); in_tag = 1;
        tick();
        check("bp_first", {val32, rdy32, tag32}, {1'b1, 1'b1, 32'd1});
        in_tag = 2; in_instr = rand_instr();
        tick();
        check("bp_full32", {rdy32, tag32}, {1'b0, 32'd1});
        check("bp_full64", {rdy64, tag64}, {1'b0, 32'd1});
        in_tag = 3; in_instr = rand_instr();
        repeat (3) begin
            tick();
            check("bp_stall", {val32, rdy32, tag32}, {1'b1, 1'b0, 32'd1});
        end
        begin
            int base;
            base = n_out32;
            out_ready = 1'b1;
            for (int c = 0; c < 30 && in_valid; c++) begin
                @(negedge clk);
                fire = in_valid && rdy32;
                tick();
                if (fire) begin
                    if (in_tag == 4) in_valid = 1'b0;
                    else begin
                        in_tag = in_tag + 1;
                        in_instr = rand_instr();
                    end
                end
            end
            for (int c = 0; c < 20 && (val32 || q32.size() != 0); c++) tick();
            check("bp_count", n_out32 - base, 4);
        end

        // Flush with both entries full and a tag presented.
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 10; in_instr = rand_instr();
        tick();
        in_tag = 11;
        tick();
        in_tag = 12; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_full32", {val32, rdy32}, 2'b01);
        check("flush_full64", {val64, rdy64}, 2'b01);
        in_tag = 13; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("flush_next", {val32, tag32}, {1'b1, 32'd13});
        tick(); tick();

        // Flush that coincides with a handshake: the handshaked tag is dropped.
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 14;
        tick();
        in_tag = 15; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_acc", {val32, rdy32}, 2'b01);
        tick();
        check("flush_gone", {val32, val64}, 2'b00);

        // Reset mid-stream with the buffer full.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_tag = 30 + i; in_instr = rand_instr();
            tick();
        end
        out_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("mid_reset");
        in_tag = 40; in_instr = rand_instr(); out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_reset", {val32, tag32, val64, tag64}, {1'b1, 32'd40, 1'b1, 32'd40});
        tick(); tick();

        // Randomised traffic checked by the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_tag    = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && (q32.size() != 0 || q64.size() != 0); c++) tick();
        tick();
        check("drain32", q32.size(), 0);
        check("drain64", q64.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-generation stage for the RISC-V decode pipeline. It accepts one 32-bit instruction per cycle from the IF/ID register over a valid/ready handshake. It classifies the instruction format, extracts and sign-extends the immediate to XLEN for all base formats (I, S, B, U, J), and presents the result one cycle later with a two-entry skid buffer so back-pressure never drops data. It sits between IF/ID and the ID/EX register and replaces the combinational immediate generator.

## Interface
- XLEN, 32 — datapath width; legal values 32 or 64.
- TAG_W, 32 — width of the opaque sideband (PC, rd index, etc.) carried alongside each instruction.
- clk  in  1  — single clock; all state on rising edge.
- reset  in  1  — synchronous, active-high; clears all state.
- flush  in  1  — synchronous pipeline flush; discards buffered entries.
- in_valid  in  1  — instruction presented.
- in_ready  out  1  — stage can accept; registered.
- in_instr  in  32  — raw instruction word.
- in_tag  in  TAG_W  — sideband.
- out_valid  out  1  — result available.
- out_ready  in  1  — consumer accepts.
- out_imm  out  XLEN  — sign-extended immediate.
- out_fmt  out  3  — format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_tag  out  TAG_W  — sideband of the same instruction.
- out_illegal  out  1  — opcode not recognised.

## Operation
- Opcode is in_instr[6:0]. Format mapping:
  - 0x03, 0x13, 0x67, 0x73 → I.
  - 0x1B → I only when XLEN=64; otherwise ILL.
  - 0x23 → S; 0x63 → B; 0x37, 0x17 → U; 0x6F → J.
  - 0x33 → R, and 0x3B → R when XLEN=64.
  - Anything else → ILL.
- Immediate extraction; bit 31 is always the sign source, replicated up to XLEN-1:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R and ILL produce out_imm = 0. ILL sets out_illegal=1; the entry still flows through so the exception is raised in order.
- Storage is two entries: an output register (OR) driving the out_* ports, and a skid register (SK).
- Accept when in_valid && in_ready:
  - Load OR if OR is empty, or if OR is being consumed this cycle and SK is empty.
  - Otherwise load SK.
- Consume when out_valid && out_ready. If SK is full, SK moves to OR; any new accept in that cycle goes to SK.
- in_ready is registered and equals !SK_full for the next cycle.
- Sustained throughput is one instruction per cycle while out_ready=1.
- Entries leave in strict acceptance order.

## Timing
- Latency: an instruction accepted at edge N appears on out_* after edge N, so it is visible in cycle N+1.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_tag=0, out_illegal=0. Both entries are empty.
- reset or flush asserted at edge N:
  - Both entries are empty after N.
  - An instruction handshaked in cycle N is discarded.
  - in_ready=1 in cycle N+1.
- reset has priority over flush; flush has priority over accept and consume.
- Full condition (OR and SK both valid, out_ready=0): in_ready=0. Nothing is accepted or overwritten.
- Simultaneous consume and accept while full: SK→OR. in_ready was 0, so no accept occurs; in_ready returns to 1 next cycle.
- While out_valid=1 and out_ready=0, out_* must be held stable.
- Reset or flush mid-stream leaves no partial entries; the first post-reset output is the first post-reset accept.

## Structure
- Package imm_pkg holds:
  - Opcode localparams (OPC_LOAD=0x03, OPC_OPIMM=0x13, OPC_JALR=0x67, OPC_SYSTEM=0x73, OPC_OPIMM32=0x1B, OPC_STORE=0x23, OPC_BRANCH=0x63, OPC_LUI=0x37, OPC_AUIPC=0x17, OPC_JAL=0x6F, OPC_OP=0x33, OPC_OP32=0x3B).
  - The 3-bit imm_fmt_t enum.
- Sub-module imm_extract: purely combinational. It takes instr and returns fmt, illegal and the XLEN immediate, parametrised by XLEN. imm_decode_stage instantiates it on the input side and adds the OR/SK buffer and control.

## Test plan
- XLEN=32, out_ready=1, back-to-back inputs:
  - 0xFFC12083 → imm 0xFFFFFFFC, fmt I.
  - 0x00512423 → imm 0x00000008, fmt S.
  - 0xFE000CE3 → imm 0xFFFFFFF8, fmt B.
  - Each result appears one cycle after accept, with no bubbles.
- XLEN=32, LUI and JAL:
  - 0x123450B7 → imm 0x12345000, fmt U.
  - 0x0010006F → imm 0x00000800, fmt J.
  - 0x00000033 → imm 0, fmt R.
  - 0x0000007F → fmt ILL, out_illegal=1.
- XLEN=64:
  - 0x800000B7 → imm 0xFFFFFFFF80000000.
  - 0x0000001B → fmt I.
  - With XLEN=32, 0x0000001B → ILL.
- Back-pressure: hold out_ready=0 and stream tags 1..4.
  - Tags 1 and 2 are accepted; in_ready=0 from the cycle after the second accept.
  - Release out_ready: outputs are 1, 2, 3, 4 in order, none lost or duplicated.
  - out_* stays stable while stalled.
- Flush with both entries full and in_valid=1: next cycle out_valid=0, in_ready=1, and the flushed and concurrent tags never appear.
- Reset asserted mid-stream for one cycle: all outputs return to reset values next cycle; the first output afterward is the first instruction accepted after reset.
